// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_OUT resets, waits for lock, releases them one by one; RESET_SEQ_LOCK_TIMEOUT_EN adds a sticky lock timeout flag
module reset_sequencer #(
  parameter int NUM_OUT      = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_DELAY  = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_reset_req,
  input  logic               locked,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               seq_done,
  output logic               busy,
  output logic               lock_timeout
);
  localparam int MAX_HS  = HOLD_CYCLES > STAGE_DELAY ? HOLD_CYCLES : STAGE_DELAY;
  localparam int MAX_ALL = MAX_HS > LOCK_TIMEOUT ? MAX_HS : LOCK_TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL) + 1;
  localparam int IW      = NUM_OUT > 1 ? $clog2(NUM_OUT) : 1;
  typedef enum logic [1:0] {S_ASSERT, S_WAIT_LOCK, S_RELEASE, S_DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               seq_done_q, seq_done_d;
  logic               busy_q, busy_d;
  logic               restart, step;
  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
      busy_q     <= busy_d;
    end
  end
  // next state: soft request beats lock loss beats normal progress
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    step    = 1'b0;
    restart = soft_reset_req || (!locked && (state_q == S_RELEASE || state_q == S_DONE));
    if (restart) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_ASSERT: begin
          state_d = cnt_q == CW'(HOLD_CYCLES - 1) ? S_WAIT_LOCK : S_ASSERT;
          cnt_d   = cnt_q == CW'(HOLD_CYCLES - 1) ? '0 : cnt_q + CW'(1);
        end
        S_WAIT_LOCK: begin
          state_d = locked ? S_RELEASE : S_WAIT_LOCK;
          idx_d   = locked ? '0 : idx_q;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
          cnt_d   = locked ? '0 : cnt_q == CW'(LOCK_TIMEOUT - 1) ? cnt_q : cnt_q + CW'(1);
`else
          cnt_d   = locked ? '0 : &cnt_q ? cnt_q : cnt_q + CW'(1);
`endif
        end
        S_RELEASE: begin
          step    = cnt_q == CW'(STAGE_DELAY - 1);
          cnt_d   = step ? '0 : cnt_q + CW'(1);
          idx_d   = step ? idx_q + IW'(1) : idx_q;
          state_d = step && idx_q == IW'(NUM_OUT - 1) ? S_DONE : S_RELEASE;
        end
        default: state_d = S_DONE;
      endcase
    end
  end
  // outputs follow the next state; released bits are only ever re-set all together
  always_comb begin
    rst_out_d  = (state_d == S_ASSERT || state_d == S_WAIT_LOCK) ? '1 :
                 step ? rst_out_q & ~(NUM_OUT'(1) << idx_q) : rst_out_q;
    seq_done_d = state_d == S_DONE;
    busy_d     = state_d != S_DONE;
  end
  assign rst_out  = rst_out_q;
  assign seq_done = seq_done_q;
  assign busy     = busy_q;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
  logic lock_timeout_q, lock_timeout_d;
  // sticky timeout flag, cleared only by reset or soft request
  always_comb begin
    lock_timeout_d = soft_reset_req ? 1'b0 :
                     (state_q == S_WAIT_LOCK && !locked && cnt_q == CW'(LOCK_TIMEOUT - 1)) ? 1'b1 :
                     lock_timeout_q;
  end
  // timeout flag register
  always_ff @(posedge clk) begin
    if (reset) lock_timeout_q <= 1'b0;
    else lock_timeout_q <= lock_timeout_d;
  end
  assign lock_timeout = lock_timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random checks of reset_sequencer against a timeline model
module tb_reset_sequencer;
  localparam int N  = 4;
  localparam int HC = 16;
  localparam int SD = 8;
  localparam int LT = 32;
  logic         clk, reset, soft_reset_req, locked;
  logic [N-1:0] rst_out;
  logic         seq_done, busy, lock_timeout;
  int           checks, fails;
  int           n, since, lock_at, waited;
  logic         flag, exp_done;
  logic [N-1:0] exp_rst;
  reset_sequencer #(.NUM_OUT(N), .HOLD_CYCLES(HC), .STAGE_DELAY(SD), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .locked(locked),
    .rst_out(rst_out), .seq_done(seq_done), .busy(busy), .lock_timeout(lock_timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask
  task automatic model_edge(input logic r, input logic s, input logic l);
    int rel;
    logic [N-1:0] ones;
    ones = '1;
    n++;
    if (r || s || (!l && lock_at >= 0)) begin
      since   = n;
      lock_at = -1;
      waited  = 0;
      if (r || s) flag = 1'b0;
    end else if (lock_at < 0 && n > since + HC) begin
      if (l) lock_at = n;
      else begin
        waited++;
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        if (waited >= LT) flag = 1'b1;
`endif
      end
    end
    rel = lock_at < 0 ? 0 : (n - lock_at) / SD;
    if (rel > N) rel = N;
    exp_rst  = ones << rel;
    exp_done = lock_at >= 0 && rel == N;
  endtask
  task automatic cyc(input logic r, input logic s, input logic l);
    reset = r;
    soft_reset_req = s;
    locked = l;
    @(posedge clk);
    model_edge(r, s, l);
    #1;
    chk("rst_out", 32'(rst_out), 32'(exp_rst));
    chk("seq_done", 32'(seq_done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(!exp_done));
    chk("lock_timeout", 32'(lock_timeout), 32'(flag));
  endtask
  task automatic measure(input string tag);
    int fall[N];
    int done_at;
    for (int i = 0; i < N; i++) fall[i] = 0;
    done_at = 0;
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    for (int k = 1; k <= 60; k++) begin
      cyc(0, 0, 1);
      for (int i = 0; i < N; i++) if (fall[i] == 0 && !rst_out[i]) fall[i] = k;
      if (done_at == 0 && seq_done) done_at = k;
    end
    for (int i = 0; i < N; i++) chk($sformatf("%s_fall%0d", tag, i), 32'(fall[i]), 32'(HC + 1 + SD * (i + 1)));
    chk({tag, "_done_edge"}, 32'(done_at), 32'(HC + 1 + SD * N));
  endtask
  initial begin
    int fall0;
    logic l;
    checks = 0; fails = 0; n = 0; since = 0; lock_at = -1; waited = 0;
    flag = 1'b0; exp_done = 1'b0; exp_rst = '1;
    reset = 1'b1; soft_reset_req = 1'b0; locked = 1'b1;
    measure("basic");
    cyc(1, 0, 0);
    for (int k = 0; k < 100; k++) cyc(0, 0, 0);
    chk("nolock_held", 32'(rst_out), 32'hF);
    for (int k = 0; k < 60; k++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    for (int k = 1; k <= 37; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("drop_rst", 32'(rst_out), 32'hF);
    chk("drop_done", 32'(seq_done), 32'h0);
    for (int k = 0; k < 70; k++) cyc(0, 0, 1);
    chk("replay_done", 32'(seq_done), 32'h1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1);
    chk("soft_rst", 32'(rst_out), 32'hF);
    fall0 = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(0, 0, 1);
      if (fall0 == 0 && !rst_out[0]) fall0 = k;
    end
    chk("soft_fall0", 32'(fall0), 32'(HC + 1 + SD));
    cyc(1, 0, 1);
    for (int k = 0; k < 30; k++) cyc(0, 0, 1);
    measure("midrst");
    l = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (l && $urandom_range(0, 99) == 0) l = 1'b0;
      else if (!l && $urandom_range(0, 9) == 0) l = 1'b1;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0, l);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
